rgb_pwm_fader: RTL and testbench

//   Drives the board RGB LED pins from per-channel duty targets with glitch-free PWM.

---
 rtl/rgb_pwm_fader_if.sv | 10 +
 rtl/rgb_pwm_fader.sv | 85 ++++++++
 tb/tb_rgb_pwm_fader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_fader_if.sv
// rgb_pwm_fader_if: duty-target handshake between pattern logic and the PWM fader
interface rgb_pwm_fader_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] tgt_r_i;
  logic [WIDTH-1:0] tgt_g_i;
  logic [WIDTH-1:0] tgt_b_i;
  logic             valid_i;
  logic             ready_o;
  modport master (output tgt_r_i, tgt_g_i, tgt_b_i, valid_i, input ready_o);
  modport slave  (input tgt_r_i, tgt_g_i, tgt_b_i, valid_i, output ready_o);
endinterface

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel glitch-free PWM LED driver with linear per-period fading
module rgb_pwm_fader #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rgb_pwm_fader_if.slave  bus,
  output logic            busy_o,
  output logic            period_o,
  output logic            led_r_o,
  output logic            led_g_o,
  output logic            led_b_o
);
  localparam int   PW  = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic OFF = ACTIVE_LOW != 0;
  typedef enum logic {IDLE, FADE} state_t;
  state_t           r_state, w_next;
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty_r, r_duty_g, r_duty_b;
  logic [WIDTH-1:0] r_tgt_r, r_tgt_g, r_tgt_b;
  logic [WIDTH-1:0] w_step_r, w_step_g, w_step_b;
  logic             r_period, r_led_r, r_led_g, r_led_b;
  logic             w_tick, w_bound, w_accept, w_done;
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t);
    return d < t ? d + 1'b1 : d > t ? d - 1'b1 : d;
  endfunction
  assign w_tick      = r_pre == PW'(PRESCALE - 1);
  assign w_bound     = w_tick && &r_cnt;
  assign bus.ready_o = r_state == IDLE && rst_ni;
  assign w_accept    = bus.valid_i && bus.ready_o;
  assign w_step_r    = step(r_duty_r, r_tgt_r);
  assign w_step_g    = step(r_duty_g, r_tgt_g);
  assign w_step_b    = step(r_duty_b, r_tgt_b);
  assign w_done      = w_step_r == r_tgt_r && w_step_g == r_tgt_g && w_step_b == r_tgt_b;
  assign busy_o      = r_state == FADE;
  assign period_o    = r_period;
  assign led_r_o     = r_led_r;
  assign led_g_o     = r_led_g;
  assign led_b_o     = r_led_b;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? FADE : IDLE) : (w_bound && w_done ? IDLE : FADE);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end
  // Duties only move on the period boundary so each PWM period uses one duty from cnt=0
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      r_period <= 1'b0;
      r_duty_r <= '0;
      r_duty_g <= '0;
      r_duty_b <= '0;
      r_tgt_r  <= '0;
      r_tgt_g  <= '0;
      r_tgt_b  <= '0;
      r_led_r  <= OFF;
      r_led_g  <= OFF;
      r_led_b  <= OFF;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      r_cnt    <= r_cnt + WIDTH'(w_tick);
      r_period <= w_bound;
      r_led_r  <= OFF ^ (r_cnt < r_duty_r);
      r_led_g  <= OFF ^ (r_cnt < r_duty_g);
      r_led_b  <= OFF ^ (r_cnt < r_duty_b);
      if (w_accept) begin
        r_tgt_r <= bus.tgt_r_i;
        r_tgt_g <= bus.tgt_g_i;
        r_tgt_b <= bus.tgt_b_i;
      end
      if (r_state == FADE && w_bound) begin
        r_duty_r <= w_step_r;
        r_duty_g <= w_step_g;
        r_duty_b <= w_step_b;
      end
    end
  end
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed fade vectors plus reset, boundary-accept and prescale sequences
module tb_rgb_pwm_fader;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic busy, period, led_r, led_g, led_b;
  logic busy3, period3, led_r3, led_g3, led_b3;
  int checks = 0;
  int errors = 0;
  int m_r = 0, m_g = 0, m_b = 0;
  int t_r = 0, t_g = 0, t_b = 0;
  always #5 clk = ~clk;
  rgb_pwm_fader_if #(.WIDTH(4)) bus ();
  rgb_pwm_fader_if #(.WIDTH(4)) bus3 ();
  rgb_pwm_fader #(.WIDTH(4), .PRESCALE(1), .ACTIVE_LOW(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .busy_o(busy), .period_o(period),
    .led_r_o(led_r), .led_g_o(led_g), .led_b_o(led_b));
  rgb_pwm_fader #(.WIDTH(4), .PRESCALE(3), .ACTIVE_LOW(1)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus3), .busy_o(busy3), .period_o(period3),
    .led_r_o(led_r3), .led_g_o(led_g3), .led_b_o(led_b3));
  typedef struct {
    int r, g, b, len;
    bit poke, at_bnd;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic wait_period(input string name);
    int k = 0;
    while (!period && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(period), 1);
  endtask
  task automatic measure(output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (16) begin
      @(negedge clk);
      lr += int'(led_r == 1'b0);
      lg += int'(led_g == 1'b0);
      lb += int'(led_b == 1'b0);
    end
    chk("period_sync", 32'(period), 1);
  endtask
  task automatic check_lit(input string tag);
    int lr, lg, lb;
    measure(lr, lg, lb);
    chk({tag, "_lit_r"}, lr, m_r);
    chk({tag, "_lit_g"}, lg, m_g);
    chk({tag, "_lit_b"}, lb, m_b);
  endtask
  function automatic int mstep(input int d, input int t);
    if (d == t) return d;
    return t > d ? d + 1 : d - 1;
  endfunction
  task automatic fade_loop(input int exp_len);
    int n = 0;
    bit done = 0;
    while (!done && n < 20) begin
      n++;
      m_r = mstep(m_r, t_r);
      m_g = mstep(m_g, t_g);
      m_b = mstep(m_b, t_b);
      done = m_r == t_r && m_g == t_g && m_b == t_b;
      chk("busy_after_bnd", 32'(busy), 32'(!done));
      check_lit("fade");
    end
    chk("fade_len", n, exp_len);
  endtask
  task automatic count_to_period(input string name, input int exp);
    int k = 0;
    while (!period && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(name, k, exp);
  endtask
  task automatic count_period3(input string name);
    int k = 0;
    while (period3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!period3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period3 && k < 200);
    chk(name, k, 48);
  endtask
  initial begin
    tbl[0] = '{4, 0, 15, 15, 1'b0, 1'b0};
    tbl[1] = '{15, 8, 15, 11, 1'b1, 1'b0};
    tbl[2] = '{0, 8, 15, 15, 1'b0, 1'b0};
    tbl[3] = '{0, 8, 15, 1, 1'b0, 1'b0};
    tbl[4] = '{3, 3, 3, 12, 1'b0, 1'b0};
    tbl[5] = '{5, 3, 3, 2, 1'b0, 1'b1};
    bus.valid_i = 1'b0; bus.tgt_r_i = '0; bus.tgt_g_i = '0; bus.tgt_b_i = '0;
    bus3.valid_i = 1'b0; bus3.tgt_r_i = '0; bus3.tgt_g_i = '0; bus3.tgt_b_i = '0;
    repeat (10) @(negedge clk);
    chk("rst_led_r", 32'(led_r), 1);
    chk("rst_led_g", 32'(led_g), 1);
    chk("rst_led_b", 32'(led_b), 1);
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_period", 32'(period), 0);
    rst_ni = 1'b1;
    #1 chk("release_ready", 32'(bus.ready_o), 1);
    count_to_period("first_period", 16);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].at_bnd) repeat (15) @(negedge clk);
      t_r = tbl[i].r; t_g = tbl[i].g; t_b = tbl[i].b;
      bus.tgt_r_i = 4'(t_r); bus.tgt_g_i = 4'(t_g); bus.tgt_b_i = 4'(t_b);
      bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      chk("accept_busy", 32'(busy), 1);
      chk("accept_ready", 32'(bus.ready_o), 0);
      if (tbl[i].at_bnd) begin
        chk("accept_on_bnd_period", 32'(period), 1);
        check_lit("no_step_on_accept");
      end else begin
        if (tbl[i].poke) begin
          bus.tgt_r_i = 4'd1;
          bus.valid_i = 1'b1;
          #1 chk("poke_ready", 32'(bus.ready_o), 0);
          @(negedge clk);
          bus.valid_i = 1'b0;
        end
        wait_period("bnd1");
      end
      fade_loop(tbl[i].len);
    end
    t_r = 15; t_g = 15; t_b = 0;
    bus.tgt_r_i = 4'd15; bus.tgt_g_i = 4'd15; bus.tgt_b_i = 4'd0;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    wait_period("rst_bnd1");
    repeat (2) begin
      @(negedge clk);
      wait_period("rst_bnd");
    end
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_led_r", 32'(led_r), 1);
    chk("midrst_led_g", 32'(led_g), 1);
    chk("midrst_led_b", 32'(led_b), 1);
    chk("midrst_ready", 32'(bus.ready_o), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_period", 32'(period), 0);
    rst_ni = 1'b1;
    #1 chk("midrst_release_ready", 32'(bus.ready_o), 1);
    count_to_period("midrst_first_period", 16);
    chk("midrst_idle", 32'(busy), 0);
    m_r = 0; m_g = 0; m_b = 0;
    check_lit("after_rst");
    count_period3("prescale3_a");
    count_period3("prescale3_b");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
